// File: rtl/motion_overlay.sv
`timescale 1ns/1ps
// motion_overlay: consumer end of the vecgen tile-vector interface.
// Collects per-tile motion flags into a write bank and copies the write bank
// to a display bank at each frame end. The incoming pixel stream is re-emitted
// one cycle later. Each tile that is flagged in the display bank gets a
// coloured border drawn around it.
module motion_overlay #(
  parameter int          H_ACTIVE     = 1280,
  parameter int          V_ACTIVE     = 720,
  parameter int          GX           = 16,
  parameter int          GY           = 16,
  parameter int          BORDER_W     = 2,
  parameter logic [23:0] BORDER_COLOR = 24'hFF0000,
  parameter int          VSYNC_ACTIVE = 0
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vec_we,
  input  logic [7:0]  vec_addr,
  input  logic        motion_detected,
  input  logic        overlay_en,
  input  logic [23:0] s_pData,
  input  logic        s_pVDE,
  input  logic        s_pHSync,
  input  logic        s_pVSync,
  output logic [23:0] m_pData,
  output logic        m_pVDE,
  output logic        m_pHSync,
  output logic        m_pVSync,
  output logic [8:0]  tile_count,
  output logic        frame_done
);

  // Tile geometry and counter widths
  localparam int TW  = H_ACTIVE / GX;
  localparam int TH  = V_ACTIVE / GY;
  localparam int NT  = GX * GY;
  localparam int PXW = (TW > 1) ? $clog2(TW) : 1;
  localparam int TXW = $clog2(GX + 1);
  localparam int PYW = (TH > 1) ? $clog2(TH) : 1;
  localparam int TYW = (GY > 1) ? $clog2(GY) : 1;
  localparam int AW  = (NT > 1) ? $clog2(NT) : 1;

  // Sized compare constants
  localparam logic [PXW-1:0] PX_MAX = PXW'(TW - 1);
  localparam logic [PXW-1:0] BW_PX  = PXW'(BORDER_W);
  localparam logic [PXW-1:0] PX_HI  = PXW'(TW - BORDER_W);
  localparam logic [PXW-1:0] PX_ONE = PXW'(1'b1);
  localparam logic [TXW-1:0] TX_SAT = TXW'(GX);
  localparam logic [TXW-1:0] TX_ONE = TXW'(1'b1);
  localparam logic [PYW-1:0] PY_MAX = PYW'(TH - 1);
  localparam logic [PYW-1:0] BW_PY  = PYW'(BORDER_W);
  localparam logic [PYW-1:0] PY_HI  = PYW'(TH - BORDER_W);
  localparam logic [PYW-1:0] PY_ONE = PYW'(1'b1);
  localparam logic [TYW-1:0] TY_MAX = TYW'(GY - 1);
  localparam logic [TYW-1:0] TY_ONE = TYW'(1'b1);
  localparam logic [8:0]     NT_W   = 9'(NT);
  localparam logic           VS_LVL = (VSYNC_ACTIVE != 0) ? 1'b1 : 1'b0;

  // Flag banks and population counters
  logic [NT-1:0]  wbank_r;
  logic [NT-1:0]  dbank_r;
  logic [NT-1:0]  wbank_next_s;
  logic [8:0]     wcnt_r;
  logic [8:0]     wcnt_next_s;
  logic [8:0]     tile_count_r;
  logic           frame_done_r;
  logic           addr_ok_s;
  logic           old_bit_s;

  // Raster position
  logic [PXW-1:0] px_r;
  logic [PXW-1:0] px_next_s;
  logic [TXW-1:0] tx_r;
  logic [TXW-1:0] tx_next_s;
  logic [PYW-1:0] py_r;
  logic [PYW-1:0] py_next_s;
  logic [TYW-1:0] ty_r;
  logic [TYW-1:0] ty_next_s;

  // Stream events and overlay decision
  logic           line_end_s;
  logic           frame_end_s;
  logic           vs_edge_s;
  logic           border_s;
  logic           hit_s;
  logic [AW-1:0]  tile_idx_s;

  // Output stage and vsync history
  logic [23:0]    m_data_r;
  logic           m_vde_r;
  logic           m_hs_r;
  logic           m_vs_r;
  logic           vs_d_r;

  // Apply the incoming tile flag to the write bank and keep its population count
  always_comb begin
    wbank_next_s = wbank_r;
    wcnt_next_s  = wcnt_r;
    addr_ok_s    = ({1'b0, vec_addr} < NT_W);
    old_bit_s    = wbank_r[vec_addr];
    if (vec_we && addr_ok_s) begin
      wbank_next_s[vec_addr] = motion_detected;
      if (motion_detected && !old_bit_s) begin
        wcnt_next_s = wcnt_r + 9'd1;
      end else if (!motion_detected && old_bit_s) begin
        wcnt_next_s = wcnt_r - 9'd1;
      end else begin
        wcnt_next_s = wcnt_r;
      end
    end else begin
      wbank_next_s = wbank_r;
    end
  end

  // Detect line end, frame end and the vsync edge into its active level.
  // The registered m_vde_r doubles as the one-cycle-delayed VDE.
  always_comb begin
    line_end_s  = m_vde_r & ~s_pVDE;
    frame_end_s = line_end_s && (py_r == PY_MAX) && (ty_r == TY_MAX);
    vs_edge_s   = (s_pVSync == VS_LVL) && (vs_d_r != VS_LVL);
  end

  // Next raster position. A vsync edge wins over everything, and a frame end
  // still triggers the swap through frame_end_s.
  always_comb begin
    px_next_s = px_r;
    tx_next_s = tx_r;
    py_next_s = py_r;
    ty_next_s = ty_r;
    if (vs_edge_s) begin
      px_next_s = '0;
      tx_next_s = '0;
      py_next_s = '0;
      ty_next_s = '0;
    end else if (s_pVDE) begin
      if (px_r == PX_MAX) begin
        px_next_s = '0;
        if (tx_r != TX_SAT) begin
          tx_next_s = tx_r + TX_ONE;
        end else begin
          tx_next_s = tx_r;
        end
      end else begin
        px_next_s = px_r + PX_ONE;
      end
    end else if (line_end_s) begin
      px_next_s = '0;
      tx_next_s = '0;
      if (py_r == PY_MAX) begin
        py_next_s = '0;
        if (ty_r == TY_MAX) begin
          ty_next_s = '0;
        end else begin
          ty_next_s = ty_r + TY_ONE;
        end
      end else begin
        py_next_s = py_r + PY_ONE;
      end
    end else begin
      px_next_s = px_r;
    end
  end

  // Decide whether the current pixel lies on the border of a flagged tile
  always_comb begin
    tile_idx_s = AW'(ty_r) * AW'(GX) + AW'(tx_r);
    border_s   = (px_r < BW_PX) || (px_r >= PX_HI) ||
                 (py_r < BW_PY) || (py_r >= PY_HI);
    if (s_pVDE && overlay_en && (tx_r < TX_SAT)) begin
      hit_s = dbank_r[tile_idx_s] & border_s;
    end else begin
      hit_s = 1'b0;
    end
  end

  // Write bank and its running count
  always_ff @(posedge pclk) begin
    if (!rst) begin
      wbank_r <= '0;
      wcnt_r  <= 9'd0;
    end else begin
      wbank_r <= wbank_next_s;
      wcnt_r  <= wcnt_next_s;
    end
  end

  // Copy the write bank to the display bank at each frame end. The copy
  // includes any write made in the same cycle.
  always_ff @(posedge pclk) begin
    if (!rst) begin
      dbank_r      <= '0;
      tile_count_r <= 9'd0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= frame_end_s;
      if (frame_end_s) begin
        dbank_r      <= wbank_next_s;
        tile_count_r <= wcnt_next_s;
      end
    end
  end

  // Raster position registers
  always_ff @(posedge pclk) begin
    if (!rst) begin
      px_r <= '0;
      tx_r <= '0;
      py_r <= '0;
      ty_r <= '0;
    end else begin
      px_r <= px_next_s;
      tx_r <= tx_next_s;
      py_r <= py_next_s;
      ty_r <= ty_next_s;
    end
  end

  // One-cycle output stage and the vsync history used for edge detection
  always_ff @(posedge pclk) begin
    if (!rst) begin
      m_data_r <= 24'h000000;
      m_vde_r  <= 1'b0;
      m_hs_r   <= 1'b1;
      m_vs_r   <= 1'b1;
      vs_d_r   <= ~VS_LVL;
    end else begin
      m_data_r <= hit_s ? BORDER_COLOR : s_pData;
      m_vde_r  <= s_pVDE;
      m_hs_r   <= s_pHSync;
      m_vs_r   <= s_pVSync;
      vs_d_r   <= s_pVSync;
    end
  end

  assign m_pData    = m_data_r;
  assign m_pVDE     = m_vde_r;
  assign m_pHSync   = m_hs_r;
  assign m_pVSync   = m_vs_r;
  assign tile_count = tile_count_r;
  assign frame_done = frame_done_r;

endmodule
